// File: rtl/tff_pkg.sv
// Shared types and constants for the toggle-event decoder.
package tff_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int TFF_MIN_SYNC = 2;

  // Fewer than two flops gives no metastability margin, so smaller requests are raised.
  function automatic int clampSync(input int n);
    return (n < TFF_MIN_SYNC) ? TFF_MIN_SYNC : n;
  endfunction

endpackage

// File: rtl/tff_toggle_decoder_if.sv
// Event-side signals of the toggle decoder; slave is the decoder's view.
interface tff_toggle_decoder_if #(
  parameter int CNT_W  = 8,
  parameter int PEND_W = 4
);
  logic              t_q;
  logic              pulse;
  logic [CNT_W-1:0]  evt_count;
  logic              evt_valid;
  logic              evt_ready;
  logic [PEND_W-1:0] pending;
  logic              overflow;
  logic              clr_ovf;

  modport master (
    output t_q, evt_ready, clr_ovf,
    input  pulse, evt_count, evt_valid, pending, overflow
  );

  modport slave (
    input  t_q, evt_ready, clr_ovf,
    output pulse, evt_count, evt_valid, pending, overflow
  );
endinterface

// File: rtl/sync_chain.sv
// Single-bit synchroniser chain with synchronous reset to 0.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/tff_toggle_decoder.sv
// Recovers one pulse per transition of a toggle line and queues events
// in a saturating pending counter behind a valid/ready handshake.
module tff_toggle_decoder
  import tff_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int PEND_W      = 4
) (
  input logic                 clk,
  input logic                 reset,
  tff_toggle_decoder_if.slave bus
);

  localparam int              STAGES    = clampSync(SYNC_STAGES);
  localparam int              CW        = $clog2(STAGES + 1);
  localparam logic [CW-1:0]   INIT_LOAD = CW'(STAGES);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            r_state, w_stateNext;
  logic [CW-1:0]     r_initCnt, w_initCntNext;
  logic              r_prev, w_prevNext;
  logic              r_pulse, w_pulseNext;
  logic [CNT_W-1:0]  r_evtCount, w_evtCountNext;
  logic [PEND_W-1:0] r_pending, w_pendingNext;
  logic              r_overflow, w_overflowNext;
  logic              w_syncLast, w_evtValid, w_det, w_con;

  sync_chain #(.STAGES(STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.t_q),
    .o_q   (w_syncLast)
  );

  assign w_evtValid = (r_pending != '0);

  // INIT waits until the chain holds the post-reset level, then adopts it as the
  // reference so the idle level is never reported as an event.
  always_comb begin
    w_stateNext    = r_state;
    w_initCntNext  = r_initCnt;
    w_prevNext     = r_prev;
    w_pulseNext    = 1'b0;
    w_evtCountNext = r_evtCount;
    w_pendingNext  = r_pending;
    w_overflowNext = r_overflow & ~bus.clr_ovf;
    w_det          = 1'b0;
    w_con          = 1'b0;
    case (r_state)
      INIT: begin
        if (r_initCnt == '0) begin
          w_prevNext  = w_syncLast;
          w_stateNext = RUN;
        end else begin
          w_initCntNext = r_initCnt - CW'(1);
        end
      end
      RUN: begin
        w_det = (w_syncLast != r_prev);
        w_con = w_evtValid & bus.evt_ready;
        if (w_det) begin
          w_pulseNext    = 1'b1;
          w_prevNext     = w_syncLast;
          w_evtCountNext = r_evtCount + CNT_W'(1);
        end
        // A simultaneous arrival and consume cancel, even when saturated.
        if (w_det && !w_con) begin
          if (r_pending == PEND_MAX) w_overflowNext = 1'b1;
          else                       w_pendingNext  = r_pending + PEND_W'(1);
        end else if (!w_det && w_con) begin
          w_pendingNext = r_pending - PEND_W'(1);
        end
      end
      default: w_stateNext = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= INIT;
      r_initCnt  <= INIT_LOAD;
      r_prev     <= 1'b0;
      r_pulse    <= 1'b0;
      r_evtCount <= '0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_initCnt  <= w_initCntNext;
      r_prev     <= w_prevNext;
      r_pulse    <= w_pulseNext;
      r_evtCount <= w_evtCountNext;
      r_pending  <= w_pendingNext;
      r_overflow <= w_overflowNext;
    end
  end

  assign bus.pulse     = r_pulse;
  assign bus.evt_count = r_evtCount;
  assign bus.evt_valid = w_evtValid;
  assign bus.pending   = r_pending;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_tff_toggle_decoder.sv
// Directed bench for tff_toggle_decoder with hand-computed expectations.
module tb_tff_toggle_decoder;

  logic clk;
  logic reset;
  logic tq;
  int   compared;
  int   mismatched;
  int   pulseCount;
  int   pulseMark;

  tff_toggle_decoder_if #(.CNT_W(8), .PEND_W(4)) bus ();

  tff_toggle_decoder #(
    .SYNC_STAGES (2),
    .CNT_W       (8),
    .PEND_W      (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial pulseCount = 0;
  always @(negedge clk) if (bus.pulse === 1'b1) pulseCount++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic tqVal, input logic ready, input logic clr);
    tq            = tqVal;
    bus.t_q       = tqVal;
    bus.evt_ready = ready;
    bus.clr_ovf   = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pulse"},    32'(bus.pulse),     0);
    checkOutput({tag, "_count"},    32'(bus.evt_count), 0);
    checkOutput({tag, "_pending"},  32'(bus.pending),   0);
    checkOutput({tag, "_valid"},    32'(bus.evt_valid), 0);
    checkOutput({tag, "_overflow"}, 32'(bus.overflow),  0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(3);
    checkResetState("rst");
    reset = 1'b0;

    // Idle level of 1 at reset exit must not be reported
    pulseMark = pulseCount;
    tick(20);
    checkOutput("idle_pulses",  32'(pulseCount - pulseMark), 0);
    checkOutput("idle_count",   32'(bus.evt_count), 0);
    checkOutput("idle_pending", 32'(bus.pending),   0);

    // 18 toggles, consumer always ready, 3-cycle latency
    applyStimulus(tq, 1'b1, 1'b0);
    pulseMark = pulseCount;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(~tq, 1'b1, 1'b0);
      tick(2);
      if (i == 0) checkOutput("lat_early", 32'(bus.pulse), 0);
      tick(1);
      checkOutput("lat_pulse",   32'(bus.pulse),   1);
      checkOutput("lat_pending", 32'(bus.pending), 1);
      tick(1);
      checkOutput("lat_drain",   32'(bus.pending), 0);
      if (i == 0) checkOutput("lat_single", 32'(bus.pulse), 0);
      tick(1);
    end
    checkOutput("run_pulses",   32'(pulseCount - pulseMark), 18);
    checkOutput("run_count",    32'(bus.evt_count), 18);
    checkOutput("run_overflow", 32'(bus.overflow),  0);

    // 20 toggles with no consumer: saturate at 15 and flag overflow
    pulseMark = pulseCount;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(~tq, 1'b0, 1'b0);
      tick(5);
    end
    checkOutput("sat_pulses",   32'(pulseCount - pulseMark), 20);
    checkOutput("sat_count",    32'(bus.evt_count), 38);
    checkOutput("sat_pending",  32'(bus.pending),   15);
    checkOutput("sat_valid",    32'(bus.evt_valid), 1);
    checkOutput("sat_overflow", 32'(bus.overflow),  1);
    applyStimulus(tq, 1'b0, 1'b1);
    tick(1);
    applyStimulus(tq, 1'b0, 1'b0);
    checkOutput("clr_overflow", 32'(bus.overflow), 0);
    checkOutput("clr_pending",  32'(bus.pending),  15);
    applyStimulus(tq, 1'b1, 1'b0);
    tick(14);
    checkOutput("drain_14", 32'(bus.pending), 1);
    tick(1);
    checkOutput("drain_15", 32'(bus.pending),   0);
    checkOutput("drain_valid", 32'(bus.evt_valid), 0);
    applyStimulus(tq, 1'b0, 1'b0);

    // Refill to 15, then arrival and consume in the same cycle
    for (int i = 0; i < 15; i++) begin
      applyStimulus(~tq, 1'b0, 1'b0);
      tick(5);
    end
    checkOutput("fill_pending",  32'(bus.pending),  15);
    checkOutput("fill_overflow", 32'(bus.overflow), 0);
    applyStimulus(~tq, 1'b0, 1'b0);
    tick(2);
    applyStimulus(tq, 1'b1, 1'b0);
    tick(1);
    applyStimulus(tq, 1'b0, 1'b0);
    checkOutput("both_pulse",    32'(bus.pulse),     1);
    checkOutput("both_pending",  32'(bus.pending),   15);
    checkOutput("both_overflow", 32'(bus.overflow),  0);
    checkOutput("both_count",    32'(bus.evt_count), 54);

    // Drain to 5, then reset mid-operation
    applyStimulus(tq, 1'b1, 1'b0);
    tick(10);
    applyStimulus(tq, 1'b0, 1'b0);
    checkOutput("pre_rst_pending", 32'(bus.pending), 5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checkResetState("mid_rst");
    pulseMark = pulseCount;
    tick(2);
    checkOutput("init_pulses", 32'(pulseCount - pulseMark), 0);
    tick(3);
    checkOutput("init_settle", 32'(pulseCount - pulseMark), 0);
    applyStimulus(~tq, 1'b0, 1'b0);
    tick(5);
    checkOutput("post_rst_count",   32'(bus.evt_count), 1);
    checkOutput("post_rst_pending", 32'(bus.pending),   1);

    // 260 toggles from a fresh reset: 8-bit count wraps to 4
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(5);
    pulseMark = pulseCount;
    for (int i = 0; i < 260; i++) begin
      applyStimulus(~tq, 1'b1, 1'b0);
      tick(3);
    end
    tick(5);
    checkOutput("wrap_pulses",   32'(pulseCount - pulseMark), 260);
    checkOutput("wrap_count",    32'(bus.evt_count), 4);
    checkOutput("wrap_pending",  32'(bus.pending),   0);
    checkOutput("wrap_overflow", 32'(bus.overflow),  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
